// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC, issues word-aligned fetches to the I-cache,
// pairs in-order responses with their PCs and buffers them for decode.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   redirect_valid/_pc         PC change from execute (highest priority)
//   fetch_req/_addr/_ready     request channel toward the cache
//   fetch_rvalid/_rdata        in-order instruction responses
//   dec_valid/_inst/_pc/_fault head of the decode FIFO, dec_ready pops it
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ready,
   input  logic        fetch_rvalid,
   input  logic [31:0] fetch_rdata,
   output logic        dec_valid,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc,
   output logic        dec_fault,
   input  logic        dec_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]   r_pc;
   logic [31:0]   r_fault_pc;
   logic          r_fault_pend;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_icnt;
   logic [DW-1:0] r_discard;
   logic [AW-1:0] r_twp;
   logic [AW-1:0] r_trp;
   logic [AW-1:0] r_iwp;
   logic [AW-1:0] r_irp;

   logic [31:0] r_tag_mem  [DEPTH];
   logic [31:0] r_ipc_mem  [DEPTH];
   logic [31:0] r_iinst_mem[DEPTH];
   logic        r_iflt_mem [DEPTH];

   logic        w_misal;
   logic [CW:0] w_credit;
   logic        w_acc;
   logic        w_drop;
   logic        w_take;
   logic        w_resp;
   logic        w_fpush;
   logic        w_ipush;
   logic        w_pop;
   logic [31:0] w_ipc;
   logic [31:0] w_iinst;
   logic        w_iflt;

   assign w_misal  = (redirect_pc[1:0] != 2'b00);
   // slots already promised: in flight plus buffered
   assign w_credit = {1'b0, r_out} + {1'b0, r_icnt};

   assign fetch_req  = (r_state == S_RUN) && !redirect_valid &&
                       (w_credit < (CW+1)'(DEPTH));
   assign fetch_addr = r_pc;

   assign w_acc  = fetch_req && fetch_ready;
   assign w_drop = fetch_rvalid && (r_discard != '0);
   assign w_take = fetch_rvalid && (r_discard == '0) && (r_out != '0);
   // any response that consumes either a stale or a live slot
   assign w_resp = fetch_rvalid && ((r_discard != '0) || (r_out != '0));

   // fault marker enters the FIFO only once stale responses have drained
   assign w_fpush = (r_state == S_FAULT) && r_fault_pend &&
                    (r_discard == '0) && !redirect_valid;
   assign w_ipush = w_take || w_fpush;
   assign w_pop   = dec_valid && dec_ready;

   assign w_ipc   = w_take ? r_tag_mem[r_trp] : r_fault_pc;
   assign w_iinst = w_take ? fetch_rdata : NOP_INST;
   assign w_iflt  = !w_take;

   assign dec_valid = (r_icnt != '0);
   assign dec_inst  = dec_valid ? r_iinst_mem[r_irp] : 32'h0;
   assign dec_pc    = dec_valid ? r_ipc_mem[r_irp] : 32'h0;
   assign dec_fault = dec_valid && r_iflt_mem[r_irp];

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:
            w_state_nxt = (redirect_valid && w_misal) ? S_FAULT : S_RUN;
         S_RUN, S_FAULT:
            if (redirect_valid)
               w_state_nxt = w_misal ? S_FAULT : S_RUN;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   // storage needs no reset: validity lives in the pointers and counts
   always_ff @(posedge clk) begin
      if (w_acc) r_tag_mem[r_twp] <= r_pc;
      if (w_ipush) begin
         r_ipc_mem[r_iwp]   <= w_ipc;
         r_iinst_mem[r_iwp] <= w_iinst;
         r_iflt_mem[r_iwp]  <= w_iflt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_fault_pc   <= '0;
         r_fault_pend <= 1'b0;
         r_out        <= '0;
         r_icnt       <= '0;
         r_discard    <= '0;
         r_twp        <= '0;
         r_trp        <= '0;
         r_iwp        <= '0;
         r_irp        <= '0;
      end else if (redirect_valid) begin
         r_pc         <= {redirect_pc[31:2], 2'b00};
         r_fault_pc   <= redirect_pc;
         r_fault_pend <= w_misal;
         r_out        <= '0;
         r_icnt       <= '0;
         r_discard    <= r_discard + DW'(r_out) - DW'(w_resp);
         r_twp        <= '0;
         r_trp        <= '0;
         r_iwp        <= '0;
         r_irp        <= '0;
      end else begin
         if (w_acc) begin
            r_pc  <= r_pc + 32'd4;
            r_twp <= r_twp + AW'(1);
         end
         if (w_take)  r_trp <= r_trp + AW'(1);
         if (w_ipush) r_iwp <= r_iwp + AW'(1);
         if (w_pop)   r_irp <= r_irp + AW'(1);
         if (w_drop)  r_discard <= r_discard - DW'(1);
         if (w_fpush) r_fault_pend <= 1'b0;
         r_out  <= r_out + CW'(w_acc) - CW'(w_take);
         r_icnt <= r_icnt + CW'(w_ipush) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed vector table, reset/wrap sequences and a
// randomized run against a stream-level model of the fetch unit.
module tb_inst_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_rvalid;
   logic [31:0] fetch_rdata;
   logic        dec_valid;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        dec_fault;
   logic        dec_ready;

   logic        r2, rv2, fr2, rsv2, dr2;
   logic [31:0] rpc2, rd2;
   logic        req2, dv2, df2;
   logic [31:0] faddr2, dinst2, dpc2;

   int n_vec = 0;
   int n_err = 0;

   inst_fetch_unit #(
      .RESET_PC(32'h0000_0000), .DEPTH(2), .NOP_INST(NOP)
   ) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid),
      .fetch_rdata(fetch_rdata), .dec_valid(dec_valid),
      .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_fault(dec_fault),
      .dec_ready(dec_ready)
   );

   inst_fetch_unit #(
      .RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .NOP_INST(NOP)
   ) dut2 (
      .clk(clk), .reset(r2),
      .redirect_valid(rv2), .redirect_pc(rpc2),
      .fetch_req(req2), .fetch_addr(faddr2),
      .fetch_ready(fr2), .fetch_rvalid(rsv2),
      .fetch_rdata(rd2), .dec_valid(dv2),
      .dec_inst(dinst2), .dec_pc(dpc2), .dec_fault(df2),
      .dec_ready(dr2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] cdata(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req"},   fetch_req, 0);
      chk({tag, "_addr"},  fetch_addr, 32'h0);
      chk({tag, "_dv"},    dec_valid, 0);
      chk({tag, "_dinst"}, dec_inst, 0);
      chk({tag, "_dpc"},   dec_pc, 0);
      chk({tag, "_dflt"},  dec_fault, 0);
   endtask

   // leaves the bench #1 after an edge, reset just released (IDLE cycle)
   task automatic do_reset(input string tag);
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      fetch_ready = 1'b0;
      fetch_rvalid = 1'b0;
      fetch_rdata = '0;
      dec_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs(tag);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        fr;
      logic        rsv;
      logic [31:0] rd;
      logic        dr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_dv;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_flt;
   } vec_t;

   function automatic vec_t mk(
      input logic rv, input logic [31:0] rpc, input logic fr,
      input logic rsv, input logic [31:0] rd, input logic dr,
      input logic e_req, input logic [31:0] e_addr, input logic e_dv,
      input logic [31:0] e_pc, input logic [31:0] e_inst,
      input logic e_flt);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.fr = fr; v.rsv = rsv; v.rd = rd;
      v.dr = dr; v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_flt = e_flt;
      return v;
   endfunction

   // random-run model: program-order stream restarted at each redirect
   typedef struct {
      logic [31:0] a;
      int          c;
   } creq_t;

   creq_t       cq[$];
   logic [31:0] req_pc;
   logic [31:0] exp_pc;
   logic [31:0] flt_pc;
   bit          fmode;
   bit          fdone;
   int          pops;

   task automatic rnd_cycle(input int cyc, input bit allow_redir);
      bit          rd;
      logic [31:0] t;
      rd = allow_redir && ($urandom_range(0, 19) == 0);
      t = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
      redirect_valid = rd;
      redirect_pc = t;
      fetch_ready = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 3) != 0);
      if (cq.size() > 0 && cq[0].c < cyc && $urandom_range(0, 2) != 0) begin
         fetch_rvalid = 1'b1;
         fetch_rdata = cdata(cq[0].a);
         void'(cq.pop_front());
      end else begin
         fetch_rvalid = 1'b0;
         fetch_rdata = $urandom;
      end
      #1;
      if (rd || fmode) chk("rnd_noreq", fetch_req, 0);
      if (fetch_req) chk("rnd_addr", fetch_addr, req_pc);
      if (fdone && !rd) chk("rnd_fault_quiet", dec_valid, 0);
      if (dec_valid && dec_ready && !rd) begin
         pops++;
         if (fmode) begin
            chk("rnd_fpc", dec_pc, flt_pc);
            chk("rnd_finst", dec_inst, NOP);
            chk("rnd_fflt", dec_fault, 1);
            fdone = 1'b1;
         end else begin
            chk("rnd_pc", dec_pc, exp_pc);
            chk("rnd_inst", dec_inst, cdata(exp_pc));
            chk("rnd_flt", dec_fault, 0);
            exp_pc = exp_pc + 32'd4;
         end
      end
      if (fetch_req && fetch_ready && !rd) begin
         cq.push_back('{req_pc, cyc});
         req_pc = req_pc + 32'd4;
      end
      if (rd) begin
         req_pc = {t[31:2], 2'b00};
         exp_pc = req_pc;
         flt_pc = t;
         fmode = (t[1:0] != 2'b00);
         fdone = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t        tbl[$];
   logic [31:0] acc2[$];
   logic [31:0] pend2[$];
   logic [31:0] ppc2[$];
   logic [31:0] pins2[$];
   logic [31:0] e;

   initial begin
      r2 = 1'b1; rv2 = 0; rpc2 = 0; fr2 = 0; rsv2 = 0; rd2 = 0; dr2 = 0;

      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0000, 1, 1, 32'h04, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0004, 1, 0, 32'h08, 1, 32'h00, 32'hA000_0000, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h08, 1, 32'h04, 32'hA000_0004, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0008, 1, 1, 32'h0C, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_000C, 1, 0, 32'h10, 1, 32'h08, 32'hA000_0008, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h10, 1, 32'h0C, 32'hA000_000C, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0010, 0, 0, 32'h14, 1, 32'h0C, 32'hA000_000C, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h14, 1, 32'h0C, 32'hA000_000C, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h14, 1, 32'h0C, 32'hA000_000C, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h14, 1, 32'h0C, 32'hA000_000C, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h14, 1, 32'h10, 32'hA000_0010, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h14, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h14, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h14, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h18, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h100, 1, 1, 32'hA000_0014, 1, 0, 32'h1C, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0018, 1, 1, 32'h100, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0100, 1, 1, 32'h104, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0104, 1, 0, 32'h108, 1, 32'h100, 32'hA000_0100, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h108, 1, 32'h104, 32'hA000_0104, 0));
      tbl.push_back(mk(1, 32'h102, 1, 0, 0, 1, 0, 32'h108, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h100, 1, 32'h102, NOP, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h100, 1, 32'h102, NOP, 1));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h200, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h200, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0200, 1, 1, 32'h204, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 32'hA000_0204, 1, 0, 32'h208, 1, 32'h200, 32'hA000_0200, 0));

      do_reset("rst");
      foreach (tbl[i]) begin
         redirect_valid = tbl[i].rv;
         redirect_pc = tbl[i].rpc;
         fetch_ready = tbl[i].fr;
         fetch_rvalid = tbl[i].rsv;
         fetch_rdata = tbl[i].rd;
         dec_ready = tbl[i].dr;
         #1;
         chk($sformatf("t%0d_req", i), fetch_req, tbl[i].e_req);
         chk($sformatf("t%0d_addr", i), fetch_addr, tbl[i].e_addr);
         chk($sformatf("t%0d_dv", i), dec_valid, tbl[i].e_dv);
         if (tbl[i].e_dv) begin
            chk($sformatf("t%0d_dpc", i), dec_pc, tbl[i].e_pc);
            chk($sformatf("t%0d_dinst", i), dec_inst, tbl[i].e_inst);
            chk($sformatf("t%0d_dflt", i), dec_fault, tbl[i].e_flt);
         end
         @(posedge clk);
         #1;
      end

      // reset with two fetches in flight, then stray responses
      do_reset("rst2");
      fetch_ready = 1'b1;
      dec_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("m_addr4", fetch_addr, 32'h4);
      @(posedge clk); #1;
      chk("m_credit", fetch_req, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_reset_outs("midrst");
      fetch_rvalid = 1'b1;
      fetch_rdata = 32'hDEAD_BEEF;
      fetch_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("stray_dv0", dec_valid, 0);
      @(posedge clk); #1;
      chk("stray_dv1", dec_valid, 0);
      chk("stray_req", fetch_req, 1);
      chk("stray_addr", fetch_addr, 32'h0);
      fetch_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("stray_dv2", dec_valid, 0);

      // PC wrap on the second instance
      r2 = 1'b0; dr2 = 1'b1; fr2 = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (pend2.size() > 0) begin
            rsv2 = 1'b1;
            rd2 = cdata(pend2.pop_front());
         end else begin
            rsv2 = 1'b0;
            rd2 = '0;
         end
         #1;
         if (dv2) begin
            ppc2.push_back(dpc2);
            pins2.push_back(dinst2);
         end
         if (req2) begin
            acc2.push_back(faddr2);
            pend2.push_back(faddr2);
         end
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 3; i++) begin
         e = 32'hFFFF_FFF8 + 32'(4 * i);
         chk("wrap_addr", acc2.size() > i ? acc2[i] : 32'hBAD0_BAD0, e);
         chk("wrap_dpc", ppc2.size() > i ? ppc2[i] : 32'hBAD0_BAD0, e);
         chk("wrap_dinst", pins2.size() > i ? pins2[i] : 32'hBAD0_BAD0,
             cdata(e));
      end

      // randomized run
      do_reset("rst3");
      cq.delete();
      req_pc = 32'h0;
      exp_pc = 32'h0;
      flt_pc = 32'h0;
      fmode = 1'b0;
      fdone = 1'b0;
      pops = 0;
      for (int c = 0; c < 3000; c++) rnd_cycle(c, c > 3);
      chk("rnd_live", (pops > 200) ? 1 : 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
